iterative_shifter: RTL



---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 31 +++
 rtl/iterative_shifter.sv | 85 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: operation codes, FSM states
// and default geometry.
package shift_pkg;

  localparam int WIDTH_DEFAULT   = 32;
  localparam int SHAMT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift step. Given the current working word and the operation,
// produces the word after one bit of shifting.
// Optional feature: define ITER_SHIFT_ROTATE_EN to make OP_ROR a rotate-right;
// otherwise OP_ROR behaves as a logical right shift.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] next_w
);

  // One-bit step selected by the latched operation
  always_comb begin
    next_w = {1'b0, w[WIDTH-1:1]};
    case (op)
      OP_SLL: next_w = {w[WIDTH-2:0], 1'b0};
      OP_SRL: next_w = {1'b0, w[WIDTH-1:1]};
      OP_SRA: next_w = {w[WIDTH-1], w[WIDTH-1:1]};
`ifdef ITER_SHIFT_ROTATE_EN
      OP_ROR: next_w = {w[0], w[WIDTH-1:1]};
`else
      OP_ROR: next_w = {1'b0, w[WIDTH-1:1]};
`endif
      default: next_w = {1'b0, w[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: shifts one bit per clock under a start/busy/done
// handshake so the execute stage needs no wide barrel shifter.
// Optional feature macro: ITER_SHIFT_ROTATE_EN (enables rotate-right on op=11).
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   data_o
);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   next_work;
  logic [SHAMT_W-1:0] count;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op    (op_q),
    .w     (work),
    .next_w(next_work)
  );

  // Control FSM with registered busy/done/data outputs; a new request may be
  // accepted from IDLE or from the DONE cycle for back-to-back operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      op_q   <= OP_SLL;
      work   <= '0;
      count  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      data_o <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
          if (start_i) begin
            op_q  <= op_e'(op_i);
            work  <= data_i;
            count <= shamt_i;
            if (shamt_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              data_o <= data_i;
            end else begin
              state  <= ST_BUSY;
              busy_o <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          work  <= next_work;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            data_o <= next_work;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
